pcie_csr_access_arb: RTL and testbench

Round-robin arbiter and sequencer that shares the single CSR access port of the PCIe CSR block between `NUM_REQ` MMIO requesters, such as host AXI-MMIO and an internal management master. It accepts one transaction at a time and drives one `csr_write`/`csr_read` pulse. For reads it waits for `csr_readdata_valid`, then returns data or an error to the granted requester. It sits between the requester-side bridges and the CSR slave's `csr_*` port, all in the CSR clock domain.

---
 rtl/pcie_csr_access_arb.sv | 230 +++++++++++++++++++++++
 tb/tb_pcie_csr_access_arb.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_csr_access_arb.sv
// Round-robin arbiter/sequencer sharing one CSR access port between NUM_REQ requesters.
// Optional read timeout enabled by defining PCIE_CSR_ARB_TIMEOUT_EN.
module pcie_csr_access_arb #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 20,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ-1:0]            req_32b,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*64-1:0]         req_wdata,
    input  logic [NUM_REQ*8-1:0]          req_wstrb,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [63:0]                   rsp_rdata,
    output logic                          rsp_err,
    output logic                          csr_write,
    output logic [ADDR_WIDTH-1:0]         csr_waddr,
    output logic [63:0]                   csr_wdata,
    output logic [7:0]                    csr_wstrb,
    output logic                          csr_read,
    output logic [ADDR_WIDTH-1:0]         csr_raddr,
    output logic                          csr_read_32b,
    input  logic [63:0]                   csr_readdata,
    input  logic                          csr_readdata_valid,
    output logic                          timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 4) begin : g_bad_param
        $error("pcie_csr_access_arb: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 4");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         last_grant_q, last_grant_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic                  is_wr_q, is_wr_d;
    logic                  csr_write_q, csr_write_d;
    logic                  csr_read_q, csr_read_d;
    logic [ADDR_WIDTH-1:0] csr_waddr_q, csr_waddr_d;
    logic [ADDR_WIDTH-1:0] csr_raddr_q, csr_raddr_d;
    logic [63:0]           csr_wdata_q, csr_wdata_d;
    logic [7:0]            csr_wstrb_q, csr_wstrb_d;
    logic                  csr_read_32b_q, csr_read_32b_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [63:0]           rsp_rdata_q, rsp_rdata_d;
`ifdef PCIE_CSR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  timeout_err_q, timeout_err_d;
`endif

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic          accept;

    // Rotating priority: search starts just after the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign accept    = (state_q == IDLE) && win_found;
    assign req_ready = accept ? (NUM_REQ'(1) << win_idx) : '0;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        owner_d        = owner_q;
        is_wr_d        = is_wr_q;
        csr_write_d    = 1'b0;
        csr_read_d     = 1'b0;
        csr_waddr_d    = csr_waddr_q;
        csr_raddr_d    = csr_raddr_q;
        csr_wdata_d    = csr_wdata_q;
        csr_wstrb_d    = csr_wstrb_q;
        csr_read_32b_d = csr_read_32b_q;
        rsp_valid_d    = '0;
        rsp_rdata_d    = rsp_rdata_q;
`ifdef PCIE_CSR_ARB_TIMEOUT_EN
        tmo_cnt_d      = tmo_cnt_q;
        rsp_err_d      = rsp_err_q;
        timeout_err_d  = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                // The CSR strobe is loaded on the accept edge so it appears in ISSUE.
                if (accept) begin
                    state_d        = ISSUE;
                    last_grant_d   = win_idx;
                    owner_d        = win_idx;
                    is_wr_d        = req_write[win_idx];
                    csr_read_32b_d = req_32b[win_idx];
                    if (req_write[win_idx]) begin
                        csr_write_d = 1'b1;
                        csr_waddr_d = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        csr_wdata_d = req_wdata[win_idx*64 +: 64];
                        csr_wstrb_d = req_wstrb[win_idx*8 +: 8];
                    end else begin
                        csr_read_d  = 1'b1;
                        csr_raddr_d = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    end
                end
            end
            ISSUE: begin
                if (is_wr_q) begin
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    rsp_rdata_d = '0;
`ifdef PCIE_CSR_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = RESP;
                end else begin
`ifdef PCIE_CSR_ARB_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                    state_d     = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (csr_readdata_valid) begin
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    rsp_rdata_d = csr_readdata;
`ifdef PCIE_CSR_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = RESP;
                end
`ifdef PCIE_CSR_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d   = NUM_REQ'(1) << owner_q;
                    rsp_rdata_d   = '1;
                    rsp_err_d     = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = RESP;
                end else if (tmo_cnt_q != '1) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            last_grant_q   <= IW'(NUM_REQ - 1);
            owner_q        <= '0;
            is_wr_q        <= 1'b0;
            csr_write_q    <= 1'b0;
            csr_read_q     <= 1'b0;
            csr_waddr_q    <= '0;
            csr_raddr_q    <= '0;
            csr_wdata_q    <= '0;
            csr_wstrb_q    <= '0;
            csr_read_32b_q <= 1'b0;
            rsp_valid_q    <= '0;
            rsp_rdata_q    <= '0;
`ifdef PCIE_CSR_ARB_TIMEOUT_EN
            tmo_cnt_q      <= '0;
            rsp_err_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            owner_q        <= owner_d;
            is_wr_q        <= is_wr_d;
            csr_write_q    <= csr_write_d;
            csr_read_q     <= csr_read_d;
            csr_waddr_q    <= csr_waddr_d;
            csr_raddr_q    <= csr_raddr_d;
            csr_wdata_q    <= csr_wdata_d;
            csr_wstrb_q    <= csr_wstrb_d;
            csr_read_32b_q <= csr_read_32b_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
`ifdef PCIE_CSR_ARB_TIMEOUT_EN
            tmo_cnt_q      <= tmo_cnt_d;
            rsp_err_q      <= rsp_err_d;
            timeout_err_q  <= timeout_err_d;
`endif
        end
    end

    assign csr_write    = csr_write_q;
    assign csr_waddr    = csr_waddr_q;
    assign csr_wdata    = csr_wdata_q;
    assign csr_wstrb    = csr_wstrb_q;
    assign csr_read     = csr_read_q;
    assign csr_raddr    = csr_raddr_q;
    assign csr_read_32b = csr_read_32b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
`ifdef PCIE_CSR_ARB_TIMEOUT_EN
    assign rsp_err      = rsp_err_q;
    assign timeout_err  = timeout_err_q;
`else
    assign rsp_err      = 1'b0;
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_pcie_csr_access_arb.sv
// Randomized bench for pcie_csr_access_arb with a transaction-timeline reference model.
module tb_pcie_csr_access_arb;

    localparam int N  = 2;
    localparam int AW = 20;
    localparam int TC = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_write = '0;
    logic [N-1:0]      req_32b = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*64-1:0]   req_wdata = '0;
    logic [N*8-1:0]    req_wstrb = '0;
    logic [N-1:0]      rsp_valid;
    logic [63:0]       rsp_rdata;
    logic              rsp_err;
    logic              csr_write;
    logic [AW-1:0]     csr_waddr;
    logic [63:0]       csr_wdata;
    logic [7:0]        csr_wstrb;
    logic              csr_read;
    logic [AW-1:0]     csr_raddr;
    logic              csr_read_32b;
    logic [63:0]       csr_readdata = '0;
    logic              csr_readdata_valid = 1'b0;
    logic              timeout_err;

    pcie_csr_access_arb #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_32b(req_32b), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .csr_write(csr_write), .csr_waddr(csr_waddr),
        .csr_wdata(csr_wdata), .csr_wstrb(csr_wstrb), .csr_read(csr_read),
        .csr_raddr(csr_raddr), .csr_read_32b(csr_read_32b),
        .csr_readdata(csr_readdata), .csr_readdata_valid(csr_readdata_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Reference model: one transaction described by the cycles its events occur in.
    bit            busy = 0;
    int            idle_from = 0;
    int            last_grant = N - 1;
    int            m_owner = 0;
    bit            m_wr = 0;
    bit            m_32b = 0;
    logic [AW-1:0] m_addr = '0;
    logic [63:0]   m_wdata = '0;
    logic [7:0]    m_wstrb = '0;
    logic [63:0]   m_sdata = '0;
    int            csr_cyc = 0;
    int            slave_cyc = 0;
    int            rsp_cyc = 0;
    logic [63:0]   exp_rdata = '0;
    bit            exp_err = 0;
    bit            exp_tmo = 0;
    int            grants[$];
    logic [N-1:0]  last_ready = '0;

    int            force_lat = -1;
    logic [63:0]   force_sdata = '0;
    bit            spur_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic do_cycle();
        logic [N-1:0] exp_rv;
        logic [N-1:0] exp_rdy;
        bit           exp_cw;
        bit           exp_cr;
        int           w;
        int           lat;
        exp_cw = busy && m_wr && (cyc == csr_cyc);
        exp_cr = busy && !m_wr && (cyc == csr_cyc);
        chk("csr_write", 64'(csr_write), 64'(exp_cw));
        if (exp_cw) begin
            chk("csr_waddr", 64'(csr_waddr), 64'(m_addr));
            chk("csr_wdata", csr_wdata, m_wdata);
            chk("csr_wstrb", 64'(csr_wstrb), 64'(m_wstrb));
        end
        chk("csr_read", 64'(csr_read), 64'(exp_cr));
        if (exp_cr) begin
            chk("csr_raddr", 64'(csr_raddr), 64'(m_addr));
            chk("csr_read_32b", 64'(csr_read_32b), 64'(m_32b));
        end
        exp_rv = '0;
        if (busy && cyc == rsp_cyc) begin
            exp_rv = N'(1) << m_owner;
            if (exp_err) exp_tmo = 1;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv != '0) begin
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_err", 64'(rsp_err), 64'(exp_err));
            busy = 0;
        end
        chk("timeout_err", 64'(timeout_err), 64'(exp_tmo));

        csr_readdata_valid = 1'b0;
        csr_readdata = {$urandom, $urandom};
        if (busy && !m_wr && cyc == slave_cyc && slave_cyc < rsp_cyc) begin
            csr_readdata_valid = 1'b1;
            csr_readdata = m_sdata;
        end else if (spur_en && (!busy || m_wr) && $urandom_range(0, 5) == 0) begin
            csr_readdata_valid = 1'b1;
        end

        #1;
        exp_rdy = '0;
        w = -1;
        if (!busy && cyc >= idle_from && req_valid != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last_grant + k) % N;
                if (w < 0 && req_valid[c]) w = c;
            end
            exp_rdy = N'(1) << w;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        last_ready = req_ready;
        if (w >= 0) begin
            busy       = 1;
            m_owner    = w;
            m_wr       = req_write[w];
            m_32b      = req_32b[w];
            m_addr     = req_addr[w*AW +: AW];
            m_wdata    = req_wdata[w*64 +: 64];
            m_wstrb    = req_wstrb[w*8 +: 8];
            last_grant = w;
            csr_cyc    = cyc + 1;
            grants.push_back(w);
            if (m_wr) begin
                rsp_cyc   = cyc + 2;
                exp_rdata = '0;
                exp_err   = 0;
            end else begin
`ifdef PCIE_CSR_ARB_TIMEOUT_EN
                lat = (force_lat >= 0) ? force_lat : $urandom_range(1, 24);
`else
                lat = (force_lat >= 0) ? force_lat : $urandom_range(1, 20);
`endif
                m_sdata   = (force_lat >= 0) ? force_sdata : {$urandom, $urandom};
                slave_cyc = cyc + 1 + lat;
                rsp_cyc   = slave_cyc + 1;
                exp_rdata = m_sdata;
                exp_err   = 0;
`ifdef PCIE_CSR_ARB_TIMEOUT_EN
                if (slave_cyc > cyc + 1 + TC) begin
                    rsp_cyc   = cyc + 2 + TC;
                    exp_rdata = '1;
                    exp_err   = 1;
                end
`endif
            end
            idle_from = rsp_cyc + 1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        csr_readdata_valid = 1'b0;
        #1;
        chk("rst_csr_write", 64'(csr_write), 64'd0);
        chk("rst_csr_read", 64'(csr_read), 64'd0);
        chk("rst_csr_waddr", 64'(csr_waddr), 64'd0);
        chk("rst_csr_raddr", 64'(csr_raddr), 64'd0);
        chk("rst_csr_wdata", csr_wdata, 64'd0);
        chk("rst_csr_wstrb", 64'(csr_wstrb), 64'd0);
        chk("rst_csr_read_32b", 64'(csr_read_32b), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset      = 1'b0;
        busy       = 0;
        last_grant = N - 1;
        exp_tmo    = 0;
        idle_from  = cyc;
    endtask

    task automatic rand_inputs();
        req_valid = N'($urandom);
        for (int i = 0; i < N; i++) begin
            req_write[i]          = 1'($urandom);
            req_32b[i]            = 1'($urandom);
            req_addr[i*AW +: AW]  = AW'($urandom);
            req_wdata[i*64 +: 64] = {$urandom, $urandom};
            req_wstrb[i*8 +: 8]   = 8'($urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_grants[6];
        exp_grants = '{0, 1, 0, 1, 0, 1};
        @(negedge clk);
        do_reset();

        // Req0 write
        req_valid = 2'b01; req_write = 2'b01;
        req_addr[0 +: AW]  = 20'h00008;
        req_wdata[0 +: 64] = 64'hA5A5_0000_1234_5678;
        req_wstrb[0 +: 8]  = 8'hFF;
        do_cycle();
        chk("wr_accept", 64'(last_ready), 64'h1);
        req_valid = '0;
        chk("wr_pulse", 64'(csr_write), 64'h1);
        chk("wr_addr", 64'(csr_waddr), 64'h8);
        chk("wr_data", csr_wdata, 64'hA5A5_0000_1234_5678);
        chk("wr_strb", 64'(csr_wstrb), 64'hFF);
        do_cycle();
        chk("wr_rsp", 64'(rsp_valid), 64'h1);
        chk("wr_rsp_err", 64'(rsp_err), 64'h0);
        do_cycle();

        // Req1 read, slave answers two cycles after csr_read
        req_valid = 2'b10; req_write = 2'b00;
        req_addr[AW +: AW] = 20'h00010;
        force_lat = 2; force_sdata = 64'h1;
        do_cycle();
        chk("rd_accept", 64'(last_ready), 64'h2);
        req_valid = '0;
        chk("rd_pulse", 64'(csr_read), 64'h1);
        chk("rd_addr", 64'(csr_raddr), 64'h10);
        for (int i = 0; i < 3; i++) do_cycle();
        chk("rd_rsp", 64'(rsp_valid), 64'h2);
        chk("rd_rdata", rsp_rdata, 64'h1);

        // Long wait: timeout variant or slow slave variant
        do_cycle();
        req_valid = 2'b01; req_write = 2'b00;
        req_addr[0 +: AW] = 20'h00020;
        force_sdata = 64'h0123_4567_89AB_CDEF;
`ifdef PCIE_CSR_ARB_TIMEOUT_EN
        force_lat = 100000;
        do_cycle();
        req_valid = '0;
        for (int i = 0; i < 17; i++) do_cycle();
        chk("tmo_rsp", 64'(rsp_valid), 64'h1);
        chk("tmo_err", 64'(rsp_err), 64'h1);
        chk("tmo_rdata", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 5; i++) do_cycle();
        chk("tmo_sticky", 64'(timeout_err), 64'h1);
`else
        force_lat = 1000;
        do_cycle();
        req_valid = 2'b11; req_write = 2'b11;
        for (int i = 0; i < 1001; i++) do_cycle();
        req_valid = '0;
        chk("slow_rsp", 64'(rsp_valid), 64'h1);
        chk("slow_err", 64'(rsp_err), 64'h0);
        chk("slow_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
        do_cycle();
`endif
        for (int i = 0; i < 4; i++) do_cycle();

        // Req0 read abandoned by reset while waiting for data
        force_lat = 100000;
        req_valid = 2'b01; req_write = 2'b00;
        do_cycle();
        req_valid = '0;
        do_cycle();
        do_reset();
        force_lat = -1;

        // Both requesters hold valid: req0 first, then strict alternation
        grants.delete();
        req_valid = 2'b11; req_write = 2'b11;
        do_cycle();
        chk("first_after_reset", 64'(last_ready), 64'h1);
        for (int i = 0; i < 80 && grants.size() < 6; i++) do_cycle();
        req_valid = '0;
        chk("alt_count", 64'(grants.size() >= 6), 64'h1);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk("alt_grant", 64'(grants[i]), 64'(exp_grants[i]));
        for (int i = 0; i < 4; i++) do_cycle();

        // Randomized traffic with spurious slave valids and occasional resets
        spur_en = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0) rand_inputs();
            if ($urandom_range(0, 499) == 0) do_reset();
            else do_cycle();
        end
        spur_en = 0;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
